// File: rtl/cu_seq_if.sv
// Handshake bundle between the sequencer and the fetch/decode/execute units.
interface cu_seq_if #(
  parameter int IR_W   = 32,
  parameter int ADDR_W = 16,
  parameter int N_EU   = 2
);
  localparam int SEL_W = $clog2(N_EU);

  logic              cs_fcu;
  logic [ADDR_W-1:0] fetch_addr;
  logic              ready_fcu;
  logic [IR_W-1:0]   ir_in;
  logic              cs_dec;
  logic              ready_dec;
  logic [SEL_W-1:0]  dec_eu;
  logic [N_EU-1:0]   cs_eu;
  logic [N_EU-1:0]   ready_eu;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;

  modport master (
    output cs_fcu, fetch_addr, cs_dec, cs_eu,
    input  ready_fcu, ir_in, ready_dec, dec_eu, ready_eu, br_valid, br_target
  );

  modport slave (
    input  cs_fcu, fetch_addr, cs_dec, cs_eu,
    output ready_fcu, ir_in, ready_dec, dec_eu, ready_eu, br_valid, br_target
  );
endinterface

// File: rtl/cu_seq_ctrl.sv
// Fetch/decode/execute sequencer: owns PC and IR, single-step, branch redirect,
// stall watchdog with sticky fault, retired-instruction counter.
module cu_seq_ctrl #(
  parameter int              IR_W     = 32,
  parameter int              ADDR_W   = 16,
  parameter int              N_EU     = 2,
  parameter int              TIMEOUT  = 255,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            step_mode,
  input  logic            step,
  cu_seq_if.master        bus,
  output logic [IR_W-1:0] ir,
  output logic [2:0]      state,
  output logic            fault,
  output logic [15:0]     instr_cnt
);
  localparam int SEL_W = $clog2(N_EU);
  localparam int WC_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_FAULT  = 3'd5
  } st_t;

  st_t               cur, nxt;
  logic [ADDR_W-1:0] pc;
  logic [SEL_W-1:0]  eu_sel;
  logic [WC_W-1:0]   wait_cnt;
  logic              sel_ready, dec_bad, timeout;

  // Only the unit picked at decode may complete EXEC.
  assign sel_ready = bus.ready_eu[eu_sel];
  // Decoder naming a unit that does not exist is treated as a fault.
  assign dec_bad   = {1'b0, bus.dec_eu} >= (SEL_W+1)'(N_EU);
  assign timeout   = (wait_cnt == WC_W'(TIMEOUT - 1));

  // Next-state: a ready in the last allowed cycle beats the watchdog.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (en && (!step_mode || step)) nxt = S_FETCH;
      S_FETCH:  if (bus.ready_fcu) nxt = S_DECODE;
                else if (timeout)  nxt = S_FAULT;
      S_DECODE: if (bus.ready_dec) nxt = dec_bad ? S_FAULT : S_EXEC;
                else if (timeout)  nxt = S_FAULT;
      S_EXEC:   if (sel_ready)     nxt = (en && !step_mode) ? S_FETCH : S_IDLE;
                else if (timeout)  nxt = S_FAULT;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Datapath: IR/EU select capture, PC update and retire count on stage completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      eu_sel    <= '0;
      instr_cnt <= '0;
    end else begin
      if (cur == S_FETCH && bus.ready_fcu) ir <= bus.ir_in;
      if (cur == S_DECODE && bus.ready_dec && !dec_bad) eu_sel <= bus.dec_eu;
      if (cur == S_EXEC && sel_ready) begin
        pc        <= bus.br_valid ? bus.br_target : pc + 1'b1;
        instr_cnt <= instr_cnt + 16'd1;
      end
    end
  end

  // Watchdog counter clears on any state change; fault is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (nxt != cur) wait_cnt <= '0;
      else if (cur == S_FETCH || cur == S_DECODE || cur == S_EXEC)
        wait_cnt <= wait_cnt + 1'b1;
      if (nxt == S_FAULT) fault <= 1'b1;
    end
  end

  assign state          = cur;
  assign bus.fetch_addr = pc;
  assign bus.cs_fcu     = (cur == S_FETCH);
  assign bus.cs_dec     = (cur == S_DECODE);
  assign bus.cs_eu      = (cur == S_EXEC) ? (N_EU'(1) << eu_sel) : '0;
endmodule

// File: tb/tb_cu_seq_ctrl.sv
// Bench for cu_seq_ctrl: directed scenarios then random traffic against a stage model.
module tb_cu_seq_ctrl;
  localparam int IR_W = 32, ADDR_W = 16, N_EU = 3, TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [IR_W-1:0] ir;
  logic [2:0]  state;
  logic        fault;
  logic [15:0] instr_cnt;

  cu_seq_if #(.IR_W(IR_W), .ADDR_W(ADDR_W), .N_EU(N_EU)) bus ();

  cu_seq_ctrl #(.IR_W(IR_W), .ADDR_W(ADDR_W), .N_EU(N_EU), .TIMEOUT(TO),
                .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .en(en), .step_mode(step_mode), .step(step),
    .bus(bus), .ir(ir), .state(state), .fault(fault), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: which stage we are in, how long we have waited there,
  // and the architectural values. Stage numbers are the published state codes.
  int          m_stage;
  int          m_age;
  logic [15:0] m_pc, m_cnt;
  logic [31:0] m_ir;
  int          m_unit;

  function automatic void m_reset();
    m_stage = 0; m_age = 0; m_pc = 16'h0; m_cnt = 16'h0; m_ir = 32'h0; m_unit = 0;
  endfunction

  // One clock edge of the model: a stage either completes on its ready or,
  // after TO cycles of waiting, the core is faulted for good.
  function automatic void m_clock();
    bit done;
    int next;
    if (m_stage == 5) return;
    if (m_stage == 0) begin
      if (en && (!step_mode || step)) m_stage = 1;
      return;
    end
    m_age++;
    done = 0;
    next = m_stage;
    if (m_stage == 1 && bus.ready_fcu) begin
      m_ir = bus.ir_in; done = 1; next = 2;
    end else if (m_stage == 2 && bus.ready_dec) begin
      done = 1;
      if (int'(bus.dec_eu) >= N_EU) next = 5;
      else begin m_unit = int'(bus.dec_eu); next = 3; end
    end else if (m_stage == 3 && bus.ready_eu[m_unit]) begin
      done = 1;
      m_pc  = bus.br_valid ? bus.br_target : m_pc + 16'd1;
      m_cnt = m_cnt + 16'd1;
      next  = (en && !step_mode) ? 1 : 0;
    end
    if (!done && m_age == TO) next = 5;
    if (next != m_stage) m_age = 0;
    m_stage = next;
  endfunction

  task automatic compare_all();
    logic [N_EU-1:0] exp_eu;
    exp_eu = (m_stage == 3) ? N_EU'(1 << m_unit) : '0;
    chk("state", 64'(state), 64'(m_stage));
    chk("cs_fcu", 64'(bus.cs_fcu), 64'(m_stage == 1));
    chk("cs_dec", 64'(bus.cs_dec), 64'(m_stage == 2));
    chk("cs_eu", 64'(bus.cs_eu), 64'(exp_eu));
    chk("fetch_addr", 64'(bus.fetch_addr), 64'(m_pc));
    chk("ir", 64'(ir), 64'(m_ir));
    chk("fault", 64'(fault), 64'(m_stage == 5));
    chk("instr_cnt", 64'(instr_cnt), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) m_reset(); else m_clock();
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    m_reset();
    compare_all();
    tick();
    reset = 1'b1;
  endtask

  task automatic drive_all_ready(input logic [1:0] eu);
    bus.ready_fcu = 1'b1; bus.ready_dec = 1'b1; bus.ready_eu = '1;
    bus.dec_eu = eu; bus.br_valid = 1'b0; bus.br_target = '0;
  endtask

  initial begin
    bus.ir_in = 32'hCAFE_0001;
    drive_all_ready(2'd1);
    #12;
    do_reset();

    // Back-to-back instructions with every ready high.
    en = 1'b1; step_mode = 1'b0;
    tick(); tick(); tick();
    chk("t1_cs_eu", 64'(bus.cs_eu), 64'(3'b010));
    repeat (4) tick();
    chk("t1_pc", 64'(bus.fetch_addr), 64'd2);
    chk("t1_cnt", 64'(instr_cnt), 64'd2);

    // Branch redirect, then wrap at the top of the address space.
    bus.br_valid = 1'b1; bus.br_target = 16'h0040;
    repeat (3) tick();
    chk("t2_branch", 64'(bus.fetch_addr), 64'h40);
    bus.br_target = 16'hFFFF;
    repeat (3) tick();
    bus.br_valid = 1'b0;
    repeat (3) tick();
    chk("t2_wrap", 64'(bus.fetch_addr), 64'h0);
    chk("t2_cnt", 64'(instr_cnt), 64'd5);

    // Single step: one pulse, one instruction; a pulse in EXEC is ignored.
    do_reset();
    step_mode = 1'b1;
    tick(); tick();
    chk("t3_idle", 64'(state), 64'd0);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick();
    step = 1'b1; bus.ready_eu = '0; tick();
    step = 1'b0; bus.ready_eu = '1; tick();
    tick(); tick();
    chk("t3_state", 64'(state), 64'd0);
    chk("t3_cnt", 64'(instr_cnt), 64'd1);

    // Watchdog: decode never answers.
    do_reset();
    step_mode = 1'b0; bus.ready_dec = 1'b0;
    tick(); tick();
    repeat (3) tick();
    chk("t4_not_yet", 64'(state), 64'd2);
    tick();
    chk("t4_fault", 64'(fault), 64'd1);
    bus.ready_dec = 1'b1;
    repeat (3) tick();
    chk("t4_cs_low", 64'({bus.cs_fcu, bus.cs_dec, bus.cs_eu}), 64'd0);

    // Watchdog: ready on the last allowed cycle wins.
    do_reset();
    bus.ready_dec = 1'b0;
    tick(); tick();
    repeat (3) tick();
    bus.ready_dec = 1'b1; tick();
    chk("t4_late_ok", 64'(state), 64'd3);
    chk("t4_no_fault", 64'(fault), 64'd0);

    // Nonexistent execute unit.
    do_reset();
    drive_all_ready(2'd3);
    repeat (3) tick();
    chk("t5_bad_eu", 64'(state), 64'd5);

    // Wrong unit's ready is ignored.
    do_reset();
    drive_all_ready(2'd2);
    bus.ready_eu = 3'b001;
    repeat (3) tick();
    repeat (3) tick();
    chk("t5_hold", 64'(state), 64'd3);
    bus.ready_eu = 3'b100; tick();
    chk("t5_retire", 64'(instr_cnt), 64'd1);

    // Reset during EXEC clears everything asynchronously.
    bus.ready_eu = 3'b000;
    tick(); tick();
    chk("t6_in_exec", 64'(state), 64'd3);
    do_reset();
    chk("t6_state", 64'(state), 64'd0);
    chk("t6_cs_eu", 64'(bus.cs_eu), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom % 8) != 0;
      step_mode = ($urandom % 4) == 0;
      step      = ($urandom % 3) == 0;
      bus.ready_fcu = ($urandom % 10) < 7;
      bus.ready_dec = ($urandom % 10) < 7;
      bus.ready_eu  = 3'($urandom);
      bus.dec_eu    = (($urandom % 12) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.ir_in     = $urandom;
      bus.br_valid  = ($urandom % 4) == 0;
      bus.br_target = 16'($urandom);
      tick();
      if (m_stage == 5 || ($urandom % 150) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
